// File: rtl/cnn_pkg.sv
// Constants and loader FSM encoding shared across the CNN front end.
package cnn_pkg;

    localparam int IMG_DIM      = 28;
    localparam int PACKED_BYTES = 98;
    localparam int GRAY_BYTES   = 784;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } loader_state_t;

endpackage

// File: rtl/image_loader.sv
// Assembles a 28x28 binary frame from a byte stream for the conv1 stage.
// Optional IMAGE_LOADER_GRAY_EN: one grayscale byte per pixel, binarized against THRESH.
module image_loader
    import cnn_pkg::*;
#(
    parameter logic [7:0] THRESH = 8'd128
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        s_data,
    input  logic                              s_valid,
    input  logic                              s_last,
    output logic                              s_ready,
    output logic [0:IMG_DIM-1][0:IMG_DIM-1]   image,
    output logic                              image_valid,
    input  logic                              image_ready,
    output logic                              frame_err,
    output logic [15:0]                       frame_count
);

`ifdef IMAGE_LOADER_GRAY_EN
    localparam int FRAME_BYTES = GRAY_BYTES;
`else
    localparam int FRAME_BYTES = PACKED_BYTES;
`endif
    localparam logic [9:0] LAST_IDX = 10'(FRAME_BYTES - 1);

    loader_state_t state;
    logic [9:0]    byte_idx;
    logic          accept;

    // Linear pixel store: pix[p] is image[p/28][p%28], so a byte lands with an indexed part-select.
    logic [0:IMG_DIM*IMG_DIM-1] pix;

    function automatic logic binarize(input logic [7:0] b);
        return b >= THRESH;
    endfunction

    // Ready is forced low while reset is held, independent of the registered state.
    assign s_ready     = !rst && (state != HOLD);
    assign image_valid = (state == HOLD);
    assign accept      = s_valid && s_ready;
    assign image       = pix;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the pixel store is reset because downstream expects an all-zero image after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            byte_idx    <= '0;
            frame_err   <= 1'b0;
            frame_count <= '0;
            pix         <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
`ifdef IMAGE_LOADER_GRAY_EN
                        pix[byte_idx] <= binarize(s_data);
`else
                        pix[{byte_idx[6:0], 3'b000} +: 8] <= s_data;
`endif
                        if (byte_idx == LAST_IDX) begin
                            byte_idx <= '0;
                            if (s_last) begin
                                state <= HOLD;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= DRAIN;
                            end
                        end else if (s_last) begin
                            // Short frame: drop it and restart on the next byte.
                            frame_err <= 1'b1;
                            byte_idx  <= '0;
                        end else begin
                            byte_idx <= byte_idx + 10'd1;
                        end
                    end
                end
                HOLD: begin
                    if (image_ready) begin
                        state       <= FILL;
                        byte_idx    <= '0;
                        frame_count <= frame_count + 16'd1;
                    end
                end
                DRAIN: begin
                    if (accept && s_last) begin
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
